// File: rtl/game_ctrl_fsm_p_if.sv
// Handshake and status bundle between the 2048 turn controller and its
// surroundings (board datapath, buttons, start/acknowledge controls).
// The controller side uses the master modport; the datapath/environment
// side uses the slave modport.
interface game_ctrl_fsm_p_if #(
    parameter int NUM_DIRS = 4,
    parameter int MOV_W    = 3,
    parameter int CNT_W    = 16
);
    // Controls and datapath status towards the controller
    logic                start;
    logic                fin;
    logic [NUM_DIRS-1:0] btn;
    logic                win;
    logic                lose;
    logic                board_changed;
    logic                step_done;

    // Controller outputs
    logic                step_start;
    logic [3:0]          estado_act;
    logic [MOV_W-1:0]    mov;
    logic [CNT_W-1:0]    move_count;
    logic                timeout_err;

    modport master (
        input  start, fin, btn, win, lose, board_changed, step_done,
        output step_start, estado_act, mov, move_count, timeout_err
    );

    modport slave (
        output start, fin, btn, win, lose, board_changed, step_done,
        input  step_start, estado_act, mov, move_count, timeout_err
    );
endinterface

// File: rtl/game_ctrl_fsm_p.sv
// 2048 game turn controller. Walks one turn through the board datapath:
// generate tile, merge, wait for a direction press, move, merge, unite,
// merge, then decide between end of game, a new tile, or waiting again.
// Every datapath phase is a start/done handshake guarded by a timeout.
module game_ctrl_fsm_p #(
    parameter int NUM_DIRS = 4,
    parameter int MOV_W    = 3,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    game_ctrl_fsm_p_if.master bus
);
    // The counter only has to reach TIMEOUT-1; the expiry fires on that value.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        ST_START  = 4'd0,
        ST_GEN    = 4'd1,
        ST_MERGE1 = 4'd2,
        ST_WAIT   = 4'd3,
        ST_MOV    = 4'd4,
        ST_MERGE2 = 4'd5,
        ST_UNIR   = 4'd6,
        ST_MERGE3 = 4'd7,
        ST_FIN    = 4'd8,
        ST_ERR    = 4'd9
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [NUM_DIRS-1:0] btn_q_reg;
    logic [NUM_DIRS-1:0] press;
    logic [MOV_W-1:0]    press_code;
    logic                any_press;
    logic [MOV_W-1:0]    mov_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                step_start_reg;
    logic                timeout_err_reg;
    logic                changed_reg;
    logic [TO_W-1:0]     to_cnt_reg;
    logic                cur_work;
    logic                next_work;
    logic                in_move_phase;
    logic                to_expired;

    function automatic logic is_work(input state_t s);
        return (s == ST_GEN)  || (s == ST_MERGE1) || (s == ST_MOV) ||
               (s == ST_MERGE2) || (s == ST_UNIR) || (s == ST_MERGE3);
    endfunction

    // Rising-edge detect per button; a held button only counts once
    for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_press
        assign press[gi] = bus.btn[gi] & ~btn_q_reg[gi];
    end

    // Lowest pressed index wins; scanning downwards leaves the lowest last
    always_comb begin
        press_code = '0;
        any_press  = 1'b0;
        for (int i = NUM_DIRS - 1; i >= 0; i--) begin
            if (press[i]) begin
                press_code = MOV_W'(i + 1);
                any_press  = 1'b1;
            end
        end
    end

    assign cur_work      = is_work(state_reg);
    assign next_work     = is_work(state_next);
    assign in_move_phase = (state_reg inside {ST_MOV, ST_MERGE2, ST_UNIR, ST_MERGE3});
    // step_done in the expiry cycle still wins because expiry requires !step_done
    assign to_expired    = TO_EN && cur_work && !bus.step_done && (to_cnt_reg == TO_LAST);

    // Next-state decision for the turn sequence
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_START:  if (bus.start)     state_next = ST_GEN;
            ST_GEN:    if (bus.step_done) state_next = ST_MERGE1;
            ST_MERGE1: if (bus.step_done) state_next = ST_WAIT;
            ST_WAIT:   if (any_press)     state_next = ST_MOV;
            ST_MOV:    if (bus.step_done) state_next = ST_MERGE2;
            ST_MERGE2: if (bus.step_done) state_next = ST_UNIR;
            ST_UNIR:   if (bus.step_done) state_next = ST_MERGE3;
            ST_MERGE3: begin
                if (bus.step_done) begin
                    if (bus.win || bus.lose)
                        state_next = ST_FIN;
                    else if (changed_reg || bus.board_changed)
                        state_next = ST_GEN;
                    else
                        state_next = ST_WAIT;
                end
            end
            ST_FIN:    if (bus.fin)       state_next = ST_START;
            ST_ERR:    if (bus.fin)       state_next = ST_START;
            default:                      state_next = ST_START;
        endcase
        if (to_expired)
            state_next = ST_ERR;
    end

    // State, registered outputs and bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_START;
            btn_q_reg       <= bus.btn;
            mov_reg         <= '0;
            count_reg       <= '0;
            step_start_reg  <= 1'b0;
            timeout_err_reg <= 1'b0;
            changed_reg     <= 1'b0;
            to_cnt_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            btn_q_reg       <= bus.btn;
            step_start_reg  <= next_work && (state_next != state_reg);
            timeout_err_reg <= (state_next == ST_ERR);

            if (state_next != state_reg)
                to_cnt_reg <= '0;
            else if (cur_work && !bus.step_done)
                to_cnt_reg <= to_cnt_reg + 1'b1;

            if (state_reg == ST_WAIT && any_press)
                mov_reg <= press_code;
            else if (state_next == ST_START)
                mov_reg <= '0;

            if (state_reg == ST_START && bus.start)
                count_reg <= '0;
            else if (state_reg == ST_WAIT && any_press && !(&count_reg))
                count_reg <= count_reg + 1'b1;

            if (state_reg == ST_WAIT && any_press)
                changed_reg <= 1'b0;
            else if (in_move_phase && bus.board_changed)
                changed_reg <= 1'b1;
        end
    end

    assign bus.step_start  = step_start_reg;
    assign bus.estado_act  = state_reg;
    assign bus.mov         = mov_reg;
    assign bus.move_count  = count_reg;
    assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_game_ctrl_fsm_p.sv
// Bench for the 2048 turn controller: directed scenarios plus randomized
// turns, with expected values derived from the turn rules (lowest pressed
// direction, saturating move count, end-of-turn decision).
module tb_game_ctrl_fsm_p;
    localparam int NUM_DIRS = 4;
    localparam int MOV_W    = 3;
    localparam int CNT_W    = 2;
    localparam int TIMEOUT  = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_count = 0;
    int   exp_mov = 0;

    game_ctrl_fsm_p_if #(.NUM_DIRS(NUM_DIRS), .MOV_W(MOV_W), .CNT_W(CNT_W)) bus ();

    game_ctrl_fsm_p #(
        .NUM_DIRS(NUM_DIRS), .MOV_W(MOV_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Direction code of a fresh press: lowest pressed button number (1-based)
    function automatic int first_dir(input logic [3:0] b);
        for (int i = 0; i < NUM_DIRS; i++)
            if (b[i]) return i + 1;
        return 0;
    endfunction

    function automatic int pick(input int dly);
        return (dly < 0) ? int'($urandom_range(0, 3)) : dly;
    endfunction

    // Drive one work phase: done after dly extra cycles; bc_mode 0=none, 1=random, 2=always
    task automatic run_phase(input int code, input int dly, input int bc_mode, output bit saw_bc);
        saw_bc = 1'b0;
        checks++;
        if (bus.estado_act !== 4'(code)) begin
            errors++;
            $display("FAIL phase_entry_state: got %0d expected %0d", bus.estado_act, code);
        end
        checks++;
        if (bus.step_start !== 1'b1) begin
            errors++;
            $display("FAIL phase_entry_step_start: state %0d got %b expected 1", code, bus.step_start);
        end
        for (int k = 0; k <= dly; k++) begin
            if (k > 0) begin
                checks++;
                if (bus.estado_act !== 4'(code)) begin
                    errors++;
                    $display("FAIL phase_hold_state: got %0d expected %0d", bus.estado_act, code);
                end
                checks++;
                if (bus.step_start !== 1'b0) begin
                    errors++;
                    $display("FAIL phase_hold_step_start: state %0d got %b expected 0", code, bus.step_start);
                end
            end
            bus.step_done = (k == dly);
            case (bc_mode)
                1:       bus.board_changed = 1'($urandom_range(0, 1));
                2:       bus.board_changed = 1'b1;
                default: bus.board_changed = 1'b0;
            endcase
            if (bus.board_changed) saw_bc = 1'b1;
            tick();
        end
        bus.step_done     = 1'b0;
        bus.board_changed = 1'b0;
    endtask

    task automatic start_game();
        bit s;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_count = 0;
        exp_mov   = 0;
        checks++;
        if (bus.move_count !== CNT_W'(0)) begin
            errors++;
            $display("FAIL start_count_clear: got %0d expected 0", bus.move_count);
        end
        run_phase(1, 0, 0, s);
        run_phase(2, 0, 0, s);
        checks++;
        if (bus.estado_act !== 4'd3) begin
            errors++;
            $display("FAIL start_reach_wait: got %0d expected 3", bus.estado_act);
        end
        checks++;
        if (bus.mov !== MOV_W'(0)) begin
            errors++;
            $display("FAIL start_mov_zero: got %0d expected 0", bus.mov);
        end
        $display("game start: state=%0d count=%0d", bus.estado_act, bus.move_count);
    endtask

    // One full move from WAIT with a fresh press of b; bc_mode 2 = changed in MOV only
    task automatic do_move(input logic [3:0] b, input int bc_mode, input bit w, input bit l,
                           input bit keep, input int dly);
        bit s;
        bit ch;
        int exp_end;
        bus.btn = b;
        tick();
        exp_mov = first_dir(b);
        if (exp_count < CNT_MAX) exp_count++;
        checks++;
        if (bus.mov !== MOV_W'(exp_mov)) begin
            errors++;
            $display("FAIL move_mov: btn=%b got %0d expected %0d", b, bus.mov, exp_mov);
        end
        checks++;
        if (bus.move_count !== CNT_W'(exp_count)) begin
            errors++;
            $display("FAIL move_count: got %0d expected %0d", bus.move_count, exp_count);
        end
        if (!keep) bus.btn = '0;
        ch = 1'b0;
        run_phase(4, pick(dly), (bc_mode == 2) ? 2 : bc_mode, s); ch |= s;
        run_phase(5, pick(dly), (bc_mode == 2) ? 0 : bc_mode, s); ch |= s;
        run_phase(6, pick(dly), (bc_mode == 2) ? 0 : bc_mode, s); ch |= s;
        bus.win  = w;
        bus.lose = l;
        run_phase(7, pick(dly), (bc_mode == 2) ? 0 : bc_mode, s); ch |= s;
        bus.win  = 1'b0;
        bus.lose = 1'b0;
        exp_end = (w || l) ? 8 : (ch ? 1 : 3);
        checks++;
        if (bus.estado_act !== 4'(exp_end)) begin
            errors++;
            $display("FAIL move_end_state: got %0d expected %0d", bus.estado_act, exp_end);
        end
        if (exp_end == 1) begin
            run_phase(1, pick(dly), 0, s);
            run_phase(2, pick(dly), 0, s);
            checks++;
            if (bus.estado_act !== 4'd3) begin
                errors++;
                $display("FAIL gen_return_wait: got %0d expected 3", bus.estado_act);
            end
        end
        checks++;
        if (bus.mov !== MOV_W'(exp_mov)) begin
            errors++;
            $display("FAIL mov_hold: got %0d expected %0d", bus.mov, exp_mov);
        end
        $display("move btn=%b mov=%0d count=%0d changed=%0d win=%0d lose=%0d end=%0d",
                 b, bus.mov, bus.move_count, ch, w, l, bus.estado_act);
    endtask

    task automatic test_reset();
        bus.btn = 4'($urandom_range(0, 15));
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.estado_act !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.estado_act); end
        checks++;
        if (bus.mov !== MOV_W'(0)) begin errors++; $display("FAIL reset_mov: got %0d expected 0", bus.mov); end
        checks++;
        if (bus.move_count !== CNT_W'(0)) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.move_count); end
        checks++;
        if (bus.step_start !== 1'b0) begin errors++; $display("FAIL reset_step_start: got %b expected 0", bus.step_start); end
        checks++;
        if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", bus.timeout_err); end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.estado_act !== 4'd0) begin errors++; $display("FAIL idle_start_state: got %0d expected 0", bus.estado_act); end
        bus.btn = '0;
        tick();
        $display("reset done: state=%0d", bus.estado_act);
    endtask

    task automatic test_start();
        start_game();
    endtask

    task automatic test_held_button();
        do_move(4'b0110, 2, 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.estado_act !== 4'd3) begin errors++; $display("FAIL held_no_move_state: got %0d expected 3", bus.estado_act); end
            checks++;
            if (bus.move_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL held_no_move_count: got %0d expected %0d", bus.move_count, exp_count); end
        end
        bus.btn = '0;
        tick();
        $display("held button released: state=%0d count=%0d", bus.estado_act, bus.move_count);
    endtask

    task automatic test_no_change();
        do_move(4'b1000, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_lose_fin();
        do_move(4'b0001, 0, 1'b0, 1'b1, 1'b0, 0);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.estado_act !== 4'd8) begin errors++; $display("FAIL fin_ignores_start: got %0d expected 8", bus.estado_act); end
        end
        bus.start = 1'b0;
        bus.fin = 1'b1;
        tick();
        bus.fin = 1'b0;
        exp_mov = 0;
        checks++;
        if (bus.estado_act !== 4'd0) begin errors++; $display("FAIL fin_to_start: got %0d expected 0", bus.estado_act); end
        checks++;
        if (bus.mov !== MOV_W'(0)) begin errors++; $display("FAIL fin_mov_clear: got %0d expected 0", bus.mov); end
        $display("fin acknowledged: state=%0d", bus.estado_act);
    endtask

    task automatic test_timeout();
        bit s;
        start_game();
        bus.btn = 4'b0100;
        tick();
        bus.btn = '0;
        exp_mov = 3;
        if (exp_count < CNT_MAX) exp_count++;
        checks++;
        if (bus.mov !== MOV_W'(exp_mov)) begin errors++; $display("FAIL timeout_mov: got %0d expected %0d", bus.mov, exp_mov); end
        run_phase(4, 0, 0, s);
        run_phase(5, 0, 0, s);
        for (int k = 0; k < TIMEOUT; k++) begin
            checks++;
            if (bus.estado_act !== 4'd6) begin errors++; $display("FAIL timeout_unir_state: cycle %0d got %0d expected 6", k, bus.estado_act); end
            checks++;
            if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_err_early: cycle %0d got %b expected 0", k, bus.timeout_err); end
            tick();
        end
        checks++;
        if (bus.estado_act !== 4'd9) begin errors++; $display("FAIL timeout_err_state: got %0d expected 9", bus.estado_act); end
        checks++;
        if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_flag: got %b expected 1", bus.timeout_err); end
        checks++;
        if (bus.step_start !== 1'b0) begin errors++; $display("FAIL timeout_step_start: got %b expected 0", bus.step_start); end
        tick();
        checks++;
        if (bus.estado_act !== 4'd9) begin errors++; $display("FAIL err_waits_fin: got %0d expected 9", bus.estado_act); end
        bus.fin = 1'b1;
        tick();
        bus.fin = 1'b0;
        exp_mov = 0;
        checks++;
        if (bus.estado_act !== 4'd0) begin errors++; $display("FAIL err_to_start: got %0d expected 0", bus.estado_act); end
        checks++;
        if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL err_flag_clear: got %b expected 0", bus.timeout_err); end
        checks++;
        if (bus.mov !== MOV_W'(0)) begin errors++; $display("FAIL err_mov_clear: got %0d expected 0", bus.mov); end
        $display("timeout recovered: state=%0d", bus.estado_act);
    endtask

    task automatic test_timeout_boundary();
        start_game();
        do_move(4'b0010, 1, 1'b0, 1'b0, 1'b0, TIMEOUT - 1);
    endtask

    task automatic test_reset_mid();
        bit s;
        bus.btn = 4'b0010;
        tick();
        run_phase(4, 0, 0, s);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count = 0;
        exp_mov = 0;
        checks++;
        if (bus.estado_act !== 4'd0) begin errors++; $display("FAIL midreset_state: got %0d expected 0", bus.estado_act); end
        checks++;
        if (bus.mov !== MOV_W'(0)) begin errors++; $display("FAIL midreset_mov: got %0d expected 0", bus.mov); end
        checks++;
        if (bus.move_count !== CNT_W'(0)) begin errors++; $display("FAIL midreset_count: got %0d expected 0", bus.move_count); end
        checks++;
        if (bus.step_start !== 1'b0) begin errors++; $display("FAIL midreset_step_start: got %b expected 0", bus.step_start); end
        start_game();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.estado_act !== 4'd3) begin errors++; $display("FAIL midreset_held_state: got %0d expected 3", bus.estado_act); end
            checks++;
            if (bus.move_count !== CNT_W'(0)) begin errors++; $display("FAIL midreset_held_count: got %0d expected 0", bus.move_count); end
        end
        bus.btn = '0;
        tick();
        do_move(4'b0010, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++)
            do_move(4'(1 << $urandom_range(0, 3)), 0, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (bus.move_count !== CNT_W'(CNT_MAX)) begin
            errors++;
            $display("FAIL saturation_count: got %0d expected %0d", bus.move_count, CNT_MAX);
        end
    endtask

    task automatic test_random();
        logic [3:0] b;
        bit w, l;
        int idle;
        for (int t = 0; t < 16; t++) begin
            idle = $urandom_range(0, 2);
            for (int i = 0; i < idle; i++) begin
                tick();
                checks++;
                if (bus.estado_act !== 4'd3) begin errors++; $display("FAIL wait_idle_state: got %0d expected 3", bus.estado_act); end
                checks++;
                if (bus.mov !== MOV_W'(exp_mov)) begin errors++; $display("FAIL wait_mov_hold: got %0d expected %0d", bus.mov, exp_mov); end
            end
            b = 4'($urandom_range(1, 15));
            w = ($urandom_range(0, 7) == 0);
            l = ($urandom_range(0, 7) == 0);
            do_move(b, int'($urandom_range(0, 1)), w, l, 1'b0, -1);
            if (w || l) begin
                bus.fin = 1'b1;
                tick();
                bus.fin = 1'b0;
                exp_mov = 0;
                checks++;
                if (bus.estado_act !== 4'd0) begin errors++; $display("FAIL rand_fin_to_start: got %0d expected 0", bus.estado_act); end
                checks++;
                if (bus.mov !== MOV_W'(0)) begin errors++; $display("FAIL rand_fin_mov: got %0d expected 0", bus.mov); end
                start_game();
            end
        end
    endtask

    initial begin
        bus.start         = 1'b0;
        bus.fin           = 1'b0;
        bus.btn           = '0;
        bus.win           = 1'b0;
        bus.lose          = 1'b0;
        bus.board_changed = 1'b0;
        bus.step_done     = 1'b0;
        test_reset();
        test_start();
        test_held_button();
        test_no_change();
        test_lose_fin();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
